// File: rtl/speed_calc_if.sv
// Signal bundle between the wheel-sensor front end, the speed calculator and its consumers.
interface speed_calc_if #(
  parameter int WIDTH = 12
) ();
  logic             tick;
  logic             reed;
  logic [WIDTH-1:0] speed;
  logic             valid;

  modport master (output tick, output reed, input speed, input valid);
  modport slave  (input tick, input reed, output speed, output valid);
endinterface

// File: rtl/speed_calc.sv
// Wheel speed from reed-switch period: counts ticks between rising edges and divides K by
// the period with a bit-serial restoring divider; saturated result with a one-cycle valid.
module speed_calc #(
  parameter int WIDTH     = 12,
  parameter int CNT_WIDTH = 16,
  parameter int KW        = 24,
  parameter int K         = 75600,
  parameter int TIMEOUT   = 3000
) (
  input logic         clk,
  input logic         r,
  speed_calc_if.slave bus
);
  localparam int IW = $clog2(KW + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] TO_VAL    = CNT_WIDTH'(TIMEOUT);
  localparam logic [KW-1:0]        K_VAL     = KW'(K);
  localparam logic [KW-1:0]        SPEED_MAX = KW'((2 ** WIDTH) - 1);
  localparam logic [IW-1:0]        ITER_INIT = IW'(KW);
  localparam logic [IW-1:0]        ITER_LAST = IW'(1);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t               r_state, w_next;
  logic                 r_reed_q, r_armed, r_pend, r_zero, r_valid;
  logic [CNT_WIDTH-1:0] r_cnt, r_pend_per, r_divisor, r_rem;
  logic [KW-1:0]        r_aq;
  logic [IW-1:0]        r_iter;
  logic [WIDTH-1:0]     r_speed;

  logic                 w_rise, w_meas, w_timeout, w_load, w_ge;
  logic [CNT_WIDTH-1:0] w_load_per, w_rem_nx;
  logic [CNT_WIDTH:0]   w_rem_sh;

  function automatic logic [WIDTH-1:0] sat_speed(input logic [KW-1:0] q, input logic zero);
    if (zero || (q > SPEED_MAX)) return '1;
    return q[WIDTH-1:0];
  endfunction

  assign w_rise    = bus.reed & ~r_reed_q;
  assign w_meas    = w_rise & r_armed;
  // A rise in the same cycle as the timeout tick is a regular measurement of TIMEOUT ticks.
  assign w_timeout = r_armed & bus.tick & (r_cnt == TO_VAL) & ~w_rise;

  // The remainder never exceeds the divisor, so a set top bit of the shifted value implies >= divisor.
  assign w_rem_sh = {r_rem, r_aq[KW-1]};
  assign w_ge     = w_rem_sh[CNT_WIDTH] | (w_rem_sh[CNT_WIDTH-1:0] >= r_divisor);
  assign w_rem_nx = w_ge ? (w_rem_sh[CNT_WIDTH-1:0] - r_divisor) : w_rem_sh[CNT_WIDTH-1:0];

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_per = r_pend_per;
    case (r_state)
      IDLE, DONE: begin
        w_next = IDLE;
        if (w_meas) begin
          w_next     = DIV;
          w_load     = 1'b1;
          w_load_per = r_cnt;
        end else if (r_pend) begin
          w_next = DIV;
          w_load = 1'b1;
        end
      end
      DIV:     if (r_iter == ITER_LAST) w_next = DONE;
      default: w_next = IDLE;
    endcase
    if (w_timeout) begin
      w_next = IDLE;
      w_load = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (r) begin
      r_state  <= IDLE;
      r_reed_q <= 1'b0;
      r_cnt    <= '0;
      r_armed  <= 1'b0;
      r_pend   <= 1'b0;
      r_speed  <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_reed_q <= bus.reed;
      if (w_rise)                              r_cnt <= {{(CNT_WIDTH-1){1'b0}}, bus.tick};
      else if (bus.tick && (r_cnt != CNT_MAX)) r_cnt <= r_cnt + 1'b1;
      if (w_timeout)   r_armed <= 1'b0;
      else if (w_rise) r_armed <= 1'b1;
      if (w_timeout)                         r_pend <= 1'b0;
      else if (w_meas && (r_state == DIV))   r_pend <= 1'b1;
      else if (w_load)                       r_pend <= 1'b0;
      r_valid <= 1'b0;
      if (w_timeout) begin
        r_speed <= '0;
        r_valid <= 1'b1;
      end else if (r_state == DONE) begin
        r_speed <= sat_speed(r_aq, r_zero);
        r_valid <= 1'b1;
      end
    end
  end

  // Divider datapath: quotient bits shift into r_aq as the numerator bits shift out.
  always_ff @(posedge clk) begin
    if (w_meas && (r_state == DIV)) r_pend_per <= r_cnt;
    if (w_load) begin
      r_aq      <= K_VAL;
      r_rem     <= '0;
      r_divisor <= w_load_per;
      r_zero    <= (w_load_per == '0);
      r_iter    <= ITER_INIT;
    end else if (r_state == DIV) begin
      r_aq   <= {r_aq[KW-2:0], w_ge};
      r_rem  <= w_rem_nx;
      r_iter <= r_iter - 1'b1;
    end
  end

  assign bus.speed = r_speed;
  assign bus.valid = r_valid;
endmodule

// File: tb/tb_speed_calc.sv
// Scoreboard bench for speed_calc: an event-level model predicts each result, a monitor compares.
module tb_speed_calc;
  localparam int WIDTH   = 12;
  localparam int KW      = 24;
  localparam int K       = 75600;
  localparam int TIMEOUT = 3000;
  localparam int SMAX    = (1 << WIDTH) - 1;

  logic clk = 1'b0;
  logic r;
  speed_calc_if #(.WIDTH(WIDTH)) bus ();

  speed_calc #(.WIDTH(WIDTH), .CNT_WIDTH(16), .KW(KW), .K(K), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .r  (r),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];
  int tick_per = 4;
  bit tick_en  = 1'b1;
  int tcnt     = 0;
  int m_cnt    = 0;
  bit m_armed  = 1'b0;
  bit m_reed   = 1'b0;
  bit prev_valid = 1'b0;
  int mon_e;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int ref_speed(input int period);
    if (period == 0) return SMAX;
    return ((K / period) > SMAX) ? SMAX : (K / period);
  endfunction

  // Time base: one-cycle tick every tick_per clocks while enabled.
  initial begin
    bus.tick = 1'b0;
    forever begin
      @(posedge clk); #1;
      tcnt = (tcnt + 1 >= tick_per) ? 0 : tcnt + 1;
      bus.tick = tick_en && (tcnt == 0);
    end
  end

  // Reference model: period = ticks since the previous rise; results queued in order.
  always @(posedge clk) begin
    if (r === 1'b1) begin
      exp_q.delete();
      m_cnt = 0; m_armed = 1'b0; m_reed = 1'b0;
    end else begin
      if (bus.reed && !m_reed) begin
        if (m_armed) exp_q.push_back(ref_speed(m_cnt));
        m_armed = 1'b1;
        m_cnt = bus.tick ? 1 : 0;
      end else if (bus.tick) begin
        if (m_armed && m_cnt == TIMEOUT) begin
          exp_q.delete();
          exp_q.push_back(0);
          m_armed = 1'b0;
        end
        if (m_cnt < 65535) m_cnt++;
      end
      m_reed = bus.reed;
    end
  end

  // Monitor: every valid strobe must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      check("valid_not_back_to_back", int'(prev_valid), 0);
      check("speed_known", int'($isunknown(bus.speed)), 0);
      check("result_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("speed", int'(bus.speed), mon_e);
      end
    end
    prev_valid = (bus.valid === 1'b1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic gap_rise(input int gap, input int hi = 2);
    cyc(gap);
    bus.reed = 1'b1;
    cyc(hi);
    bus.reed = 1'b0;
  endtask

  initial begin
    int lat;
    int w;
    r = 1'b1;
    bus.reed = 1'b0;
    cyc(4);
    r = 1'b0;
    cyc(1);
    check("reset_speed", int'(bus.speed), 0);
    check("reset_valid", int'(bus.valid), 0);

    // first edge arms, second edge 100 ticks later measures
    gap_rise(10);
    cyc(100 * 4 - 2);
    bus.reed = 1'b1;
    lat = 0;
    while (lat < 40) begin
      cyc(1);
      lat++;
      if (lat == 2) bus.reed = 1'b0;
      if (bus.valid === 1'b1) break;
    end
    check("latency", lat, KW + 2);
    check("speed_100_ticks", int'(bus.speed), 756);
    cyc(1);
    check("valid_one_cycle", int'(bus.valid), 0);

    // short period saturates, long period gives a small speed
    gap_rise(1);
    gap_rise(2100 * 4 - 2);
    cyc(60);

    // two rises with no tick between them: period 0
    tick_en = 1'b0;
    gap_rise(10);
    gap_rise(1);
    tick_en = 1'b1;
    cyc(80);

    // timeout, then re-arm, then a normal measurement
    gap_rise(50 * 4 - 2);
    cyc((TIMEOUT + 10) * 4);
    check("timeout_speed", int'(bus.speed), 0);
    gap_rise(20);
    gap_rise(150 * 4 - 2);
    cyc(60);

    // rise arriving while a division is running
    gap_rise(100 * 4 - 2);
    gap_rise(8);
    cyc(100);

    // reset in the middle of a division
    gap_rise(100);
    cyc(8);
    r = 1'b1;
    cyc(1);
    check("midreset_speed", int'(bus.speed), 0);
    check("midreset_valid", int'(bus.valid), 0);
    r = 1'b0;
    cyc(60);
    gap_rise(40);
    gap_rise(300);
    cyc(60);

    // randomized periods and tick rates
    for (int i = 0; i < 12; i++) begin
      tick_per = $urandom_range(1, 4);
      gap_rise($urandom_range(30, 700), $urandom_range(1, 20));
    end

    w = 0;
    while (exp_q.size() > 0 && w < 200) begin
      cyc(1);
      w++;
    end
    check("all_results_seen", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
